tictactoe_game_ctrl: RTL

TICTACTOE_GAME_CTRL -- requirements
Module: tictactoe_game_ctrl

---
 rtl/tictactoe_pkg.sv | 56 +++++
 rtl/tictactoe_game_ctrl_if.sv | 29 ++
 rtl/tictactoe_win_check.sv | 27 ++
 rtl/tictactoe_game_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared encodings and the eight win lines for the tic-tac-toe controller.
// No ports: cell/state/winner/action enums, constants and cursor helpers.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CHECK = 2'b01,
    ST_OVER  = 2'b10
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_O    = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_SEL,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_UP,
    ACT_DOWN
  } act_t;

  localparam logic [3:0] CURSOR_HOME = 4'd4;
  localparam logic [3:0] SCORE_MAX   = 4'd15;

  localparam int unsigned WIN_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  function automatic logic [1:0] col_of(input logic [3:0] c);
    unique case (c)
      4'd0, 4'd3, 4'd6: col_of = 2'd0;
      4'd1, 4'd4, 4'd7: col_of = 2'd1;
      default:          col_of = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] c);
    if (c < 4'd3)      row_of = 2'd0;
    else if (c < 4'd6) row_of = 2'd1;
    else               row_of = 2'd2;
  endfunction

endpackage

// File: rtl/tictactoe_game_ctrl_if.sv
// Button inputs and display/score outputs of the game controller.
// master: button driver / display side; slave: the controller.
interface tictactoe_game_ctrl_if;
  logic        btn_left;
  logic        btn_right;
  logic        btn_up;
  logic        btn_down;
  logic        btn_sel;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic        turn;
  logic [1:0]  game_state;
  logic [1:0]  winner;
  logic        menu_sel;
  logic [3:0]  score_x;
  logic [3:0]  score_o;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, btn_sel,
    input  board, cursor, turn, game_state, winner,
    input  menu_sel, score_x, score_o
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, btn_sel,
    output board, cursor, turn, game_state, winner,
    output menu_sel, score_x, score_o
  );
endinterface

// File: rtl/tictactoe_win_check.sv
// Combinational line/full detector for one mark on the 3x3 board.
// In: board[17:0], mark. Out: line_found, board_full.
module tictactoe_win_check
  import tictactoe_pkg::*;
(
  input  logic [17:0] board,
  input  cell_t       mark,
  output logic        line_found,
  output logic        board_full
);

  always_comb begin
    line_found = 1'b0;
    board_full = 1'b1;
    for (int l = 0; l < 8; l++) begin
      if (board[5'(2 * WIN_LINES[l][0]) +: 2] == mark &&
          board[5'(2 * WIN_LINES[l][1]) +: 2] == mark &&
          board[5'(2 * WIN_LINES[l][2]) +: 2] == mark)
        line_found = 1'b1;
    end
    for (int i = 0; i < 9; i++) begin
      if (board[5'(2 * i) +: 2] == CELL_EMPTY)
        board_full = 1'b0;
    end
  end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe game controller: cursor, marks, win/draw check, menu, scores.
// Ports: clk, reset (sync, active-high), bus (slave: buttons in, state out).
module tictactoe_game_ctrl
  import tictactoe_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  tictactoe_game_ctrl_if.slave bus
);

  logic [17:0] board_q, board_d;
  logic [3:0]  cursor_q, cursor_d;
  logic        turn_q, turn_d;
  game_state_t state_q, state_d;
  winner_t     winner_q, winner_d;
  logic        menu_q, menu_d;
  logic [3:0]  sx_q, sx_d;
  logic [3:0]  so_q, so_d;
  logic [4:0]  prev_q;
  logic        blank_q;
  logic [4:0]  btn, rise;
  logic [4:0]  cur_idx;
  act_t        act;
  cell_t       mark;
  logic        line_found, board_full;

  assign btn = {bus.btn_down, bus.btn_up, bus.btn_right,
                bus.btn_left, bus.btn_sel};

  // First cycle after reset only captures the button levels, so a
  // button held through reset never looks like a fresh press.
  assign rise    = blank_q ? 5'd0 : (btn & ~prev_q);
  assign mark    = turn_q ? CELL_O : CELL_X;
  assign cur_idx = {cursor_q, 1'b0};

  always_comb begin
    act = ACT_NONE;
    priority case (1'b1)
      rise[0]: act = ACT_SEL;
      rise[1]: act = ACT_LEFT;
      rise[2]: act = ACT_RIGHT;
      rise[3]: act = ACT_UP;
      rise[4]: act = ACT_DOWN;
      default: act = ACT_NONE;
    endcase
  end

  tictactoe_win_check u_win_check (
    .board      (board_q),
    .mark       (mark),
    .line_found (line_found),
    .board_full (board_full)
  );

  always_comb begin
    board_d  = board_q;
    cursor_d = cursor_q;
    turn_d   = turn_q;
    state_d  = state_q;
    winner_d = winner_q;
    menu_d   = menu_q;
    sx_d     = sx_q;
    so_d     = so_q;
    unique case (state_q)
      ST_PLAY: begin
        unique case (act)
          ACT_LEFT:
            cursor_d = (col_of(cursor_q) == 2'd0) ?
                       cursor_q + 4'd2 : cursor_q - 4'd1;
          ACT_RIGHT:
            cursor_d = (col_of(cursor_q) == 2'd2) ?
                       cursor_q - 4'd2 : cursor_q + 4'd1;
          ACT_UP:
            cursor_d = (row_of(cursor_q) == 2'd0) ?
                       cursor_q + 4'd6 : cursor_q - 4'd3;
          ACT_DOWN:
            cursor_d = (row_of(cursor_q) == 2'd2) ?
                       cursor_q - 4'd6 : cursor_q + 4'd3;
          ACT_SEL: begin
            if (board_q[cur_idx +: 2] == CELL_EMPTY) begin
              board_d[cur_idx +: 2] = mark;
              state_d = ST_CHECK;
            end
          end
          default: ;
        endcase
      end
      ST_CHECK: begin
        if (line_found) begin
          state_d = ST_OVER;
          if (turn_q) begin
            winner_d = WIN_O;
            if (so_q != SCORE_MAX) so_d = so_q + 4'd1;
          end else begin
            winner_d = WIN_X;
            if (sx_q != SCORE_MAX) sx_d = sx_q + 4'd1;
          end
        end else if (board_full) begin
          state_d  = ST_OVER;
          winner_d = WIN_DRAW;
        end else begin
          state_d = ST_PLAY;
          turn_d  = ~turn_q;
        end
      end
      ST_OVER: begin
        unique case (act)
          ACT_LEFT, ACT_RIGHT: menu_d = ~menu_q;
          ACT_SEL: begin
            board_d  = 18'd0;
            cursor_d = CURSOR_HOME;
            turn_d   = 1'b0;
            winner_d = WIN_NONE;
            menu_d   = 1'b0;
            state_d  = ST_PLAY;
            if (menu_q) begin
              sx_d = 4'd0;
              so_d = 4'd0;
            end
          end
          default: ;
        endcase
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q  <= 18'd0;
      cursor_q <= CURSOR_HOME;
      turn_q   <= 1'b0;
      state_q  <= ST_PLAY;
      winner_q <= WIN_NONE;
      menu_q   <= 1'b0;
      sx_q     <= 4'd0;
      so_q     <= 4'd0;
      prev_q   <= 5'd0;
      blank_q  <= 1'b1;
    end else begin
      board_q  <= board_d;
      cursor_q <= cursor_d;
      turn_q   <= turn_d;
      state_q  <= state_d;
      winner_q <= winner_d;
      menu_q   <= menu_d;
      sx_q     <= sx_d;
      so_q     <= so_d;
      prev_q   <= btn;
      blank_q  <= 1'b0;
    end
  end

  assign bus.board      = board_q;
  assign bus.cursor     = cursor_q;
  assign bus.turn       = turn_q;
  assign bus.game_state = state_q;
  assign bus.winner     = winner_q;
  assign bus.menu_sel   = menu_q;
  assign bus.score_x    = sx_q;
  assign bus.score_o    = so_q;

endmodule
